acia_tx_fifo: RTL

Buffered 8N1 serial transmitter: the send-side counterpart of `acia_rx`. It accepts bytes from a parallel push interface into a small FIFO and serialises them LSB-first onto a single line, using the shared peripheral-clock enable `pclk`. Its first user is the simulation bench, where it drives the SoC's `RX` pin. It is also a drop-in host-side stimulus for the boot monitor and the CIA/ACIA interrupt tests.

---
 rtl/acia_tx_fifo_pkg.sv | 21 ++
 rtl/acia_tx_fifo_if.sv | 11 +
 rtl/acia_tx_fifo_fifo.sv | 66 ++++++
 rtl/acia_tx_fifo.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/acia_tx_fifo_pkg.sv
// Shared definitions for the ACIA transmit path: FSM state encoding, frame
// constants and the baud divider helper.
package acia_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  // Ticks of the peripheral enable per serial bit, truncated toward zero.
  function automatic int acia_div(input int f, input int r);
    return f / r;
  endfunction

endpackage

// File: rtl/acia_tx_fifo_if.sv
// Parallel push interface into the ACIA transmit buffer.
interface acia_tx_fifo_if;

  logic [7:0] tx_dat;
  logic       tx_stb;
  logic       tx_rdy;

  modport master (output tx_dat, output tx_stb, input tx_rdy);
  modport slave  (input tx_dat, input tx_stb, output tx_rdy);

endinterface

// File: rtl/acia_tx_fifo_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the oldest
// entry. Pushes while full and pops while empty are ignored.
import acia_tx_fifo_pkg::*;

module acia_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("acia_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acia_tx_fifo.sv
// Buffered 8N1 serial transmitter: bytes pushed into a FIFO are sent
// LSB-first on tx_serial, bit timing derived from the pclk enable.
import acia_tx_fifo_pkg::*;

module acia_tx_fifo #(
  parameter int clk_freq = 4000000,
  parameter int sym_rate = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pclk,
  acia_tx_fifo_if.slave          tx,
  output logic                   tx_serial,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_ovf,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int DIV = acia_div(clk_freq, sym_rate);
  localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("acia_tx_fifo: clk_freq / sym_rate must be at least 2");
  end

  tx_state_t       state;
  tx_state_t       state_n;
  logic [BW-1:0]   baud;
  logic [BW-1:0]   baud_n;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_n;
  logic [7:0]      shift;
  logic [7:0]      shift_n;
  logic            serial_n;
  logic            done_n;
  logic            pop;
  logic            push;
  logic            full;
  logic            empty;
  logic            bit_end;
  logic [7:0]      fifo_dout;

  // Fullness is judged on the registered count, so a same-cycle pop never
  // makes room for a push.
  assign push      = tx.tx_stb && !full;
  assign tx.tx_rdy = !full;
  assign bit_end   = pclk && (baud == BAUD_LAST);
  assign tx_busy   = (state != IDLE) || !empty;

  acia_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (tx.tx_dat),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      tx_serial <= serial_n;
      tx_done   <= done_n;
      tx_ovf    <= tx_ovf | (tx.tx_stb & full);
    end
  end

  // The next line level is computed here and registered above; a new frame
  // is chained straight out of STOP so there is no idle gap between bytes.
  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_cnt;
    shift_n  = shift;
    serial_n = tx_serial;
    done_n   = 1'b0;
    pop      = 1'b0;

    if (pclk && state != IDLE) begin
      baud_n = bit_end ? '0 : baud + 1'b1;
    end

    case (state)
      IDLE: begin
        if (pclk && !empty) begin
          pop      = 1'b1;
          shift_n  = fifo_dout;
          serial_n = 1'b0;
          baud_n   = '0;
          state_n  = START;
        end
      end
      START: begin
        if (bit_end) begin
          serial_n = shift[0];
          bit_n    = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == BIT_LAST) begin
            serial_n = 1'b1;
            state_n  = STOP;
          end else begin
            serial_n = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_n = 1'b1;
          if (!empty) begin
            pop      = 1'b1;
            shift_n  = fifo_dout;
            serial_n = 1'b0;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
